ifetch_buffer: RTL and testbench

Instruction prefetch buffer between a multi-cycle instruction memory and the fetch stage of the pipelined MIPS core. It issues sequential word fetches over a req/ack handshake and stores the returned instructions, each tagged with its PC, in a small FIFO. The fetch stage consumes from the FIFO under its stall signal. A redirect from next-PC logic (taken branch or jump) flushes the buffer and squashes any in-flight fetch.

---
 rtl/ifetch_buffer.sv | 155 +++++++++++++++
 tb/tb_ifetch_buffer.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/ifetch_buffer.sv
// ifetch_buffer: instruction prefetch buffer between a multi-cycle instruction
// memory and the fetch stage.
//
// Issues sequential word fetches over a req/ack handshake. Each returned word is
// stored with its PC in a small FIFO, and the fetch stage pops that FIFO under
// f_stall. A redirect flushes the FIFO and restarts fetch at redirect_pc. A fetch
// that is already in flight cannot be withdrawn, so it is drained and its data
// is dropped.
//
// Ports
//   clk, rst_n           : clock (rising edge), asynchronous active-low reset
//   mem_req, mem_addr    : registered fetch request and word address
//   mem_ack, mem_rdata   : memory response, valid only while mem_req is high
//   redirect, redirect_pc: flush the buffer and restart fetch at redirect_pc
//   f_stall              : the fetch stage cannot take the head entry
//   f_valid, f_instr, f_pc: head of the FIFO
module ifetch_buffer #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        f_stall,
  output logic        f_valid,
  output logic [31:0] f_instr,
  output logic [31:0] f_pc
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, WAIT, DRAIN} state_e;

  state_e          state_q, state_d;
  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]   count_q, count_d, count_nx;
  logic [AW-1:0]   rptr_q, rptr_d, wptr_q, wptr_d;
  logic            req_q, req_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     pc_mem_q    [DEPTH];
  logic [31:0]     instr_mem_q [DEPTH];
  logic            pop, push;

  // The head shown in a redirect cycle is squashed by the fetch stage,
  // so it is not consumed here.
  assign pop  = (count_q != '0) && !f_stall && !redirect;
  assign push = (state_q == WAIT) && mem_ack && !redirect;
  assign count_nx = count_q + CW'(push) - CW'(pop);

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    count_d    = count_q;
    rptr_d     = rptr_q;
    wptr_d     = wptr_q;
    req_d      = req_q;
    addr_d     = addr_q;
    if (redirect) begin
      count_d    = '0;
      rptr_d     = '0;
      wptr_d     = '0;
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
      // An outstanding request stays up until acked; its data is never kept.
      if (state_q == WAIT || state_q == DRAIN) begin
        if (mem_ack) begin
          req_d   = 1'b0;
          state_d = IDLE;
        end else begin
          state_d = DRAIN;
        end
      end
    end else begin
      count_d = count_nx;
      if (pop)  rptr_d = rptr_q + AW'(1);
      if (push) wptr_d = wptr_q + AW'(1);
      unique case (state_q)
        IDLE: begin
          if (count_q < CW'(DEPTH)) begin
            req_d      = 1'b1;
            addr_d     = fetch_pc_q;
            fetch_pc_d = fetch_pc_q + 32'd4;
            state_d    = WAIT;
          end
        end
        WAIT: begin
          if (mem_ack) begin
            // Back-to-back issue keeps a zero-wait memory at one word/cycle.
            if (count_nx < CW'(DEPTH)) begin
              addr_d     = fetch_pc_q;
              fetch_pc_d = fetch_pc_q + 32'd4;
            end else begin
              req_d   = 1'b0;
              state_d = IDLE;
            end
          end
        end
        DRAIN: begin
          if (mem_ack) begin
            req_d   = 1'b0;
            state_d = IDLE;
          end
        end
        default: begin
          req_d   = 1'b0;
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      count_q    <= '0;
      rptr_q     <= '0;
      wptr_q     <= '0;
      req_q      <= 1'b0;
      addr_q     <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      count_q    <= count_d;
      rptr_q     <= rptr_d;
      wptr_q     <= wptr_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem_q[i]    <= '0;
        instr_mem_q[i] <= '0;
      end
    end else if (push) begin
      pc_mem_q[wptr_q]    <= addr_q;
      instr_mem_q[wptr_q] <= mem_rdata;
    end
  end

  assign mem_req  = req_q;
  assign mem_addr = addr_q;
  assign f_valid  = (count_q != '0);
  assign f_instr  = instr_mem_q[rptr_q];
  assign f_pc     = pc_mem_q[rptr_q];

endmodule

// File: tb/tb_ifetch_buffer.sv
// Bench for ifetch_buffer. Random handshake, stall and redirect traffic runs
// against a queue-based model that tracks one outstanding fetch and whether
// that fetch has been squashed.
module tb_ifetch_buffer;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0100;
  localparam int          NCYC     = 1500;
  localparam int          RST_CYC  = 600;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        f_stall;
  logic        f_valid;
  logic [31:0] f_instr;
  logic [31:0] f_pc;

  ifetch_buffer #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .f_stall(f_stall),
    .f_valid(f_valid), .f_instr(f_instr), .f_pc(f_pc)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Model state: FIFO contents {pc, instr}, next fetch address, the single
  // outstanding request and whether a redirect has orphaned it.
  logic [63:0] q[$];
  logic [31:0] m_pc;
  logic        m_req;
  logic [31:0] m_addr;
  logic        m_squash;

  function automatic void model_reset();
    q.delete();
    m_pc     = RESET_PC;
    m_req    = 1'b0;
    m_addr   = '0;
    m_squash = 1'b0;
  endfunction

  function automatic void model_issue();
    m_req  = 1'b1;
    m_addr = m_pc;
    m_pc   = m_pc + 32'd4;
  endfunction

  // Advances the model across one rising edge using the inputs now driven.
  function automatic void model_step();
    int cnt_pre;
    cnt_pre = q.size();
    if (redirect) begin
      q.delete();
      m_pc = {redirect_pc[31:2], 2'b00};
      if (m_req) begin
        if (mem_ack) begin
          m_req    = 1'b0;
          m_squash = 1'b0;
        end else begin
          m_squash = 1'b1;
        end
      end
    end else begin
      if (cnt_pre != 0 && !f_stall) void'(q.pop_front());
      if (m_req && mem_ack) begin
        if (m_squash) begin
          m_req    = 1'b0;
          m_squash = 1'b0;
        end else begin
          q.push_back({m_addr, mem_rdata});
          if (q.size() < DEPTH) model_issue();
          else m_req = 1'b0;
        end
      end else if (!m_req && cnt_pre < DEPTH) begin
        model_issue();
      end
    end
  endfunction

  task automatic check_outputs();
    logic [63:0] h;
    chk("mem_req", {31'd0, mem_req}, {31'd0, m_req});
    if (m_req) chk("mem_addr", mem_addr, m_addr);
    chk("f_valid", {31'd0, f_valid}, {31'd0, (q.size() != 0)});
    chk("count", 32'(dut.count_q), 32'(q.size()));
    if (q.size() != 0) begin
      h = q[0];
      chk("f_pc", f_pc, h[63:32]);
      chk("f_instr", f_instr, h[31:0]);
    end
  endtask

  task automatic pick_inputs(input int cyc);
    int ack_pct;
    mem_rdata   = $urandom;
    redirect    = 1'b0;
    redirect_pc = '0;
    if (cyc < 8) begin
      mem_ack = 1'b1;
      f_stall = 1'b0;
    end else if (cyc < 30) begin
      // Fill phase: stall long enough for the FIFO to fill, then drain.
      mem_ack = 1'b1;
      f_stall = (cyc < 20);
    end else begin
      ack_pct = ((cyc / 200) % 3 == 0) ? 100 : (((cyc / 200) % 3 == 1) ? 35 : 70);
      mem_ack = ($urandom_range(0, 99) < ack_pct);
      f_stall = ($urandom_range(0, 99) < 30);
      if ($urandom_range(0, 99) < 6) begin
        redirect = 1'b1;
        case ($urandom_range(0, 3))
          0:       redirect_pc = 32'hFFFF_FFFC;
          1:       redirect_pc = 32'h0000_3001;
          default: redirect_pc = $urandom;
        endcase
      end
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    mem_ack     = 1'b0;
    mem_rdata   = '0;
    redirect    = 1'b0;
    redirect_pc = '0;
    f_stall     = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_f_valid", {31'd0, f_valid}, 32'd0);
    chk("rst_f_instr", f_instr, 32'd0);
    chk("rst_f_pc", f_pc, 32'd0);
    rst_n = 1'b1;
    pick_inputs(0);
    model_step();
    for (int cyc = 1; cyc < NCYC; cyc++) begin
      @(negedge clk);
      check_outputs();
      if (cyc == RST_CYC) begin
        // Reset between edges must drop the outputs without a clock.
        #2 rst_n = 1'b0;
        #1;
        chk("async_mem_req", {31'd0, mem_req}, 32'd0);
        chk("async_f_valid", {31'd0, f_valid}, 32'd0);
        mem_ack = 1'b1;
        @(negedge clk);
        chk("async_mem_addr", mem_addr, 32'd0);
        chk("async_count", 32'(dut.count_q), 32'd0);
        model_reset();
        rst_n = 1'b1;
      end
      pick_inputs(cyc);
      model_step();
    end
    @(negedge clk);
    check_outputs();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
